// File: rtl/regbank_wr_arbiter_if.sv
// Requester/bank bus for regbank_wr_arbiter: req/gnt handshake with per-requester
// address and data in, one-hot word enable and shared write data out.
interface regbank_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int DEPTH = 16,
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(DEPTH)
);
    logic [NREQ-1:0]       req;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_lock;
    logic [NREQ-1:0]       gnt;
    logic [DEPTH-1:0]      wr_enb;
    logic [WIDTH-1:0]      wr_d;
    logic                  err_addr;
    logic                  busy;

    modport master (
        output req, req_addr, req_data, req_lock,
        input  gnt, wr_enb, wr_d, err_addr, busy
    );

    modport slave (
        input  req, req_addr, req_data, req_lock,
        output gnt, wr_enb, wr_d, err_addr, busy
    );
endinterface

// File: rtl/regbank_wr_arbiter.sv
// Round-robin write arbiter feeding a DEPTH x WIDTH enabled-register bank.
// Optional burst locking is compiled in when ARB_LOCK_EN is defined.
module regbank_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DEPTH     = 16,
    parameter int WIDTH     = 16,
    parameter int AW        = $clog2(DEPTH),
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    regbank_wr_arbiter_if.slave  bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    typedef logic [PW-1:0] idx_t;

    logic [AW-1:0]    addr_a [NREQ];
    logic [WIDTH-1:0] data_a [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_a[g] = bus.req_addr[g*AW +: AW];
        assign data_a[g] = bus.req_data[g*WIDTH +: WIDTH];
    end

    idx_t             ptr_q, ptr_d;
    logic [DEPTH-1:0] wr_enb_q, wr_enb_d;
    logic [WIDTH-1:0] wr_d_q, wr_d_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic [NREQ-1:0]  cand_req;
    logic             lock_hold;
    idx_t             lock_idx;
    logic [PW:0]      rr_sum;
    logic             rr_found;
    idx_t             rr_idx;
    logic             grant;
    idx_t             win;
    logic [NREQ-1:0]  gnt_c;

`ifdef ARB_LOCK_EN
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    idx_t            owner_q, owner_d;
    logic            owner_vld_q, owner_vld_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic            lock_excl;

    // The previous winner keeps the bus while it asks for the lock and has burst
    // budget left; once the budget is spent it sits out exactly one arbitration.
    always_comb begin
        lock_hold = owner_vld_q && bus.req[owner_q] && bus.req_lock[owner_q]
                    && (32'(burst_q) < MAX_BURST - 1);
        lock_excl = owner_vld_q && (32'(burst_q) == MAX_BURST - 1);
        lock_idx  = owner_q;
        cand_req  = bus.req;
        if (lock_excl) cand_req[owner_q] = 1'b0;
    end

    always_comb begin
        owner_d     = owner_q;
        owner_vld_d = grant;
        burst_d     = '0;
        if (grant) owner_d = win;
        if (grant && lock_hold) burst_d = burst_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            burst_q     <= '0;
        end else begin
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            burst_q     <= burst_d;
        end
    end
`else
    localparam int unused_max_burst = MAX_BURST;
    logic unused_lock;

    assign unused_lock = ^bus.req_lock;
    assign lock_hold   = 1'b0;
    assign lock_idx    = '0;
    assign cand_req    = bus.req;
`endif

    // Scan ptr, ptr+1, ... mod NREQ; walking downward lets the closest hit win.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_sum   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            rr_sum = {1'b0, ptr_q} + (PW+1)'(k);
            if (rr_sum >= (PW+1)'(NREQ)) rr_sum = rr_sum - (PW+1)'(NREQ);
            if (cand_req[rr_sum[PW-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = rr_sum[PW-1:0];
            end
        end
    end

    always_comb begin
        grant = !rst && (lock_hold || rr_found);
        win   = lock_hold ? lock_idx : rr_idx;
        gnt_c = '0;
        if (grant) gnt_c[win] = 1'b1;
    end

    // NOTE: every always_comb output gets a default before any branch so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        ptr_d    = ptr_q;
        wr_enb_d = '0;
        wr_d_d   = wr_d_q;
        err_d    = 1'b0;
        busy_d   = |gnt_c;
        if (grant) begin
            if (!lock_hold) ptr_d = (win == idx_t'(NREQ - 1)) ? idx_t'(0) : idx_t'(win + 1'b1);
            // Out-of-range addresses are still consumed, but only flag an error.
            if (32'(addr_a[win]) < DEPTH) begin
                wr_enb_d = DEPTH'(1) << addr_a[win];
                wr_d_d   = data_a[win];
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q    <= '0;
            wr_enb_q <= '0;
            wr_d_q   <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            wr_enb_q <= wr_enb_d;
            wr_d_q   <= wr_d_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.gnt      = gnt_c;
    assign bus.wr_enb   = wr_enb_q;
    assign bus.wr_d     = wr_d_q;
    assign bus.err_addr = err_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Self-checking bench for regbank_wr_arbiter: directed scenarios plus a randomized
// run against a list-scanning reference model of the arbitration rules.
module tb_regbank_wr_arbiter;
    localparam int NREQ      = 4;
    localparam int DEPTH     = 12;
    localparam int WIDTH     = 16;
    localparam int AW        = 4;
    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regbank_wr_arbiter_if #(.NREQ(NREQ), .DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) bus ();

    regbank_wr_arbiter #(
        .NREQ(NREQ), .DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW-1:0]    a_addr [NREQ];
    logic [WIDTH-1:0] a_data [NREQ];
    logic [WIDTH-1:0] bank   [DEPTH];

    // Behavioural stand-in for the enabled-register bank.
    always @(posedge clk)
        for (int i = 0; i < DEPTH; i++)
            if (bus.wr_enb[i]) bank[i] <= bus.wr_d;

    // Reference model state: next priority slot, last winner (-1 none), locked grants so far.
    int m_ptr, m_owner, m_burst;

    function automatic int model_pick(input logic [NREQ-1:0] r, input logic [NREQ-1:0] lk,
                                      output bit locked);
        int excl;
        excl   = -1;
        locked = 1'b0;
`ifdef ARB_LOCK_EN
        if (m_owner >= 0 && r[m_owner] && lk[m_owner] && m_burst < MAX_BURST - 1) begin
            locked = 1'b1;
            return m_owner;
        end
        if (m_owner >= 0 && m_burst == MAX_BURST - 1) excl = m_owner;
`else
        if (lk === 'x) excl = -1;
`endif
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    task automatic model_update(input int w, input bit locked);
        if (w < 0) begin
            m_owner = -1;
            m_burst = 0;
        end else if (locked) begin
            m_burst++;
        end else begin
            m_ptr   = (w + 1) % NREQ;
            m_owner = w;
            m_burst = 0;
        end
    endtask

    task automatic drive(input logic [NREQ-1:0] r, input logic [NREQ-1:0] lk);
        bus.req      = r;
        bus.req_lock = lk;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_addr[i*AW +: AW]       = a_addr[i];
            bus.req_data[i*WIDTH +: WIDTH] = a_data[i];
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive('0, '0);
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b0;
        m_ptr   = 0;
        m_owner = -1;
        m_burst = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NREQ; i++) begin a_addr[i] = '0; a_data[i] = '0; end
        @(negedge clk);
        rst = 1'b1;
        drive(4'b1111, '0);
        #1;
        n_checks++;
        if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL rst_gnt_held: got %b want 0000", bus.gnt); end
        n_checks++;
        if (bus.wr_enb !== '0 || bus.wr_d !== '0 || bus.err_addr !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_outputs: got enb=%h d=%h err=%b busy=%b want all 0",
                     bus.wr_enb, bus.wr_d, bus.err_addr, bus.busy);
        end
        do_reset();
        a_addr[0] = 4'd3;
        a_data[0] = 16'h1234;
        drive(4'b0001, '0);
        #1;
        n_checks++;
        if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL rst_pre_gnt: got %b want 0001", bus.gnt); end
        @(negedge clk);
        n_checks++;
        if (bus.wr_enb !== 12'h008) begin n_fail++; $display("FAIL rst_pre_enb: got %h want 008", bus.wr_enb); end
        // Mid-write reset with everyone requesting.
        rst = 1'b1;
        drive(4'b1111, '0);
        #1;
        n_checks++;
        if (bus.wr_enb !== '0 || bus.wr_d !== '0 || bus.busy !== 1'b0 || bus.gnt !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_write: got enb=%h d=%h busy=%b gnt=%b want all 0",
                     bus.wr_enb, bus.wr_d, bus.busy, bus.gnt);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL rst_ptr_zero: got %b want 0001", bus.gnt); end
        drive('0, '0);
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0]  exp_g;
        logic [DEPTH-1:0] exp_e;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            a_addr[i] = AW'(i + 2);
            a_data[i] = WIDTH'(16'hA000 + i);
        end
        drive(4'b1111, '0);
        for (int k = 0; k < 5; k++) begin
            #1;
            exp_g = NREQ'(1) << (k % NREQ);
            n_checks++;
            if (bus.gnt !== exp_g) begin n_fail++; $display("FAIL rr_gnt_%0d: got %b want %b", k, bus.gnt, exp_g); end
            @(negedge clk);
            exp_e = DEPTH'(1) << ((k % NREQ) + 2);
            n_checks++;
            if (bus.wr_enb !== exp_e || bus.wr_d !== a_data[k % NREQ]) begin
                n_fail++;
                $display("FAIL rr_write_%0d: got enb=%h d=%h want enb=%h d=%h",
                         k, bus.wr_enb, bus.wr_d, exp_e, a_data[k % NREQ]);
            end
        end
        drive('0, '0);
    endtask

    task automatic test_single_write();
        do_reset();
        a_addr[2] = 4'd5;
        a_data[2] = 16'hBEEF;
        drive(4'b0100, '0);
        #1;
        n_checks++;
        if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt: got %b want 0100", bus.gnt); end
        @(negedge clk);
        drive('0, '0);
        n_checks++;
        if (bus.wr_enb !== 12'h020 || bus.wr_d !== 16'hBEEF || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_write: got enb=%h d=%h busy=%b want 020 beef 1", bus.wr_enb, bus.wr_d, bus.busy);
        end
        @(negedge clk);
        n_checks++;
        if (bus.wr_enb !== '0 || bus.busy !== 1'b0 || bus.wr_d !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL single_after: got enb=%h busy=%b d=%h want 000 0 beef", bus.wr_enb, bus.busy, bus.wr_d);
        end
    endtask

    task automatic test_bad_addr();
        do_reset();
        a_addr[1] = 4'd13;
        a_data[1] = 16'h0BAD;
        drive(4'b0010, '0);
        #1;
        n_checks++;
        if (bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL bad_gnt: got %b want 0010", bus.gnt); end
        @(negedge clk);
        drive('0, '0);
        n_checks++;
        if (bus.wr_enb !== '0 || bus.err_addr !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_err: got enb=%h err=%b want 000 1", bus.wr_enb, bus.err_addr);
        end
        @(negedge clk);
        n_checks++;
        if (bus.err_addr !== 1'b0) begin n_fail++; $display("FAIL bad_err_pulse: got %b want 0", bus.err_addr); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        a_addr[1] = 4'd7; a_data[1] = 16'hAAAA;
        a_addr[2] = 4'd7; a_data[2] = 16'h5555;
        drive(4'b0110, '0);
        #1;
        n_checks++;
        if (bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL b2b_first: got %b want 0010", bus.gnt); end
        @(negedge clk);
        drive(4'b0100, '0);
        #1;
        n_checks++;
        if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL b2b_second: got %b want 0100", bus.gnt); end
        @(negedge clk);
        drive('0, '0);
        @(negedge clk);
        n_checks++;
        if (bank[7] !== 16'h5555) begin n_fail++; $display("FAIL b2b_later_wins: got %h want 5555", bank[7]); end
        // A lone requester is served every cycle regardless of ptr.
        a_addr[3] = 4'd11;
        a_data[3] = 16'h3333;
        drive(4'b1000, 4'b0000);
        for (int k = 0; k < 6; k++) begin
            #1;
            n_checks++;
            if (bus.gnt !== 4'b1000) begin n_fail++; $display("FAIL single_req_%0d: got %b want 1000", k, bus.gnt); end
            @(negedge clk);
        end
        n_checks++;
        if (bus.wr_enb !== 12'h800 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_req_write: got enb=%h busy=%b want 800 1", bus.wr_enb, bus.busy);
        end
        drive('0, '0);
    endtask

    task automatic test_lock();
        logic [NREQ-1:0] exp_seq [10];
`ifdef ARB_LOCK_EN
        exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010,
                    4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
`else
        exp_seq = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001,
                    4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
`endif
        do_reset();
        a_addr[0] = 4'd1; a_data[0] = 16'h0101;
        a_addr[1] = 4'd2; a_data[1] = 16'h0202;
        drive(4'b0011, 4'b0001);
        for (int k = 0; k < 10; k++) begin
            #1;
            n_checks++;
            if (bus.gnt !== exp_seq[k]) begin n_fail++; $display("FAIL lock_gnt_%0d: got %b want %b", k, bus.gnt, exp_seq[k]); end
            @(negedge clk);
        end
        drive('0, '0);
    endtask

    task automatic test_random_fairness();
        logic [NREQ-1:0]  r, prev_r, prev_g, exp_g;
        logic [DEPTH-1:0] exp_enb;
        logic [WIDTH-1:0] exp_d;
        logic             exp_err, exp_busy;
        int               w;
        bit               lkd;
        int               waitc [NREQ];
        do_reset();
        exp_enb = '0; exp_d = '0; exp_err = 1'b0; exp_busy = 1'b0;
        prev_r = '0; prev_g = '0; r = '0;
        for (int i = 0; i < NREQ; i++) waitc[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            n_checks++;
            if (bus.wr_enb !== exp_enb || bus.wr_d !== exp_d || bus.err_addr !== exp_err || bus.busy !== exp_busy) begin
                n_fail++;
                $display("FAIL rand_regs_c%0d: got enb=%h d=%h err=%b busy=%b want enb=%h d=%h err=%b busy=%b",
                         c, bus.wr_enb, bus.wr_d, bus.err_addr, bus.busy, exp_enb, exp_d, exp_err, exp_busy);
            end
            // Waiting requesters mostly keep asking with unchanged addr/data.
            for (int i = 0; i < NREQ; i++) begin
                if (prev_r[i] && !prev_g[i]) begin
                    r[i] = ($urandom_range(9) != 0);
                end else begin
                    r[i]      = 1'($urandom_range(1));
                    a_addr[i] = AW'($urandom_range(15));
                    a_data[i] = WIDTH'($urandom);
                end
            end
            drive(r, '0);
            #1;
            w     = model_pick(r, '0, lkd);
            exp_g = (w >= 0) ? (NREQ'(1) << w) : '0;
            n_checks++;
            if (bus.gnt !== exp_g) begin n_fail++; $display("FAIL rand_gnt_c%0d: got %b want %b", c, bus.gnt, exp_g); end
            for (int i = 0; i < NREQ; i++) begin
                waitc[i] = (r[i] && !bus.gnt[i]) ? waitc[i] + 1 : 0;
                if (waitc[i] > NREQ - 1) begin
                    n_fail++;
                    $display("FAIL fairness_c%0d: requester %0d waited %0d cycles, limit %0d", c, i, waitc[i], NREQ - 1);
                end
            end
            model_update(w, lkd);
            exp_busy = (w >= 0);
            if (w >= 0 && int'(a_addr[w]) < DEPTH) begin
                exp_enb = DEPTH'(1) << a_addr[w];
                exp_d   = a_data[w];
                exp_err = 1'b0;
            end else begin
                exp_enb = '0;
                exp_err = (w >= 0);
            end
            prev_r = r;
            prev_g = exp_g;
            @(negedge clk);
        end
        drive('0, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin a_addr[i] = '0; a_data[i] = '0; end
        drive('0, '0);
        test_reset();
        test_round_robin();
        test_single_write();
        test_bad_addr();
        test_back_to_back();
        test_lock();
        test_random_fairness();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
